// File: rtl/pll_mon_pkg.sv
// rtl/pll_mon_pkg.sv - shared state type, default constants and band check for the PLL monitor
package pll_mon_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } mon_state_t;

    localparam int DEF_GATE_CYCLES  = 27000;
    localparam int DEF_EXPECTED_CNT = 1875;
    localparam int DEF_TOL_CNT      = 4;
    localparam int DEF_LOCK_WINDOWS = 4;
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_STALL_CYCLES = 64;

    function automatic logic band_ok(input logic [31:0] cnt, input int unsigned expected,
                                     input int unsigned tol);
        return (cnt >= 32'(expected - tol)) && (cnt <= 32'(expected + tol));
    endfunction

endpackage

// File: rtl/pll_mon_sync_edge.sv
// rtl/pll_mon_sync_edge.sv - 2-FF synchronizer plus edge detect for an async toggle strobe
module pll_mon_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic ff1, ff2, ff3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= 1'b0;
            ff2 <= 1'b0;
            ff3 <= 1'b0;
        end else begin
            ff1 <= async_in;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    // both toggle directions are edges
    assign edge_pulse = ff2 ^ ff3;

endmodule

// File: rtl/pll_clk_monitor.sv
// rtl/pll_clk_monitor.sv - PLL frequency monitor: gated edge count, lock FSM, downstream reset
// PLLMON_STALL_DETECT_EN adds a mid-window stall detector.
module pll_clk_monitor
    import pll_mon_pkg::*;
#(
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int EXPECTED_CNT = DEF_EXPECTED_CNT,
    parameter int TOL_CNT      = DEF_TOL_CNT,
    parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
    parameter int CNT_W        = DEF_CNT_W
`ifdef PLLMON_STALL_DETECT_EN
    , parameter int STALL_CYCLES = DEF_STALL_CYCLES
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             meas_tog,
    input  logic             fault_clr,
    output logic             locked,
    output logic             rst_out_n,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid,
    output logic             fault_sticky
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WINDOWS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              edge_seen;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [GOOD_W-1:0] good_cnt;
    mon_state_t        state;
    logic              window_end;
    logic              window_good;
    logic              stall;
    logic              restart;

    pll_mon_sync_edge u_sync_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_in  (meas_tog),
        .edge_pulse(edge_seen)
    );

    assign window_end  = (gate_cnt == GATE_LAST);
    // a saturated counter means the real count is unknown, so never treat it as good
    assign window_good = band_ok(32'(edge_cnt), EXPECTED_CNT, TOL_CNT) && (edge_cnt != CNT_MAX);

`ifdef PLLMON_STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (edge_seen || stall)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign stall = !edge_seen && (stall_cnt == STALL_W'(STALL_CYCLES - 1));
`else
    assign stall = 1'b0;
`endif

    assign restart = stall && (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            freq_count  <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (restart) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
            end else if (window_end) begin
                gate_cnt    <= '0;
                freq_count  <= edge_cnt;
                count_valid <= 1'b1;
                edge_cnt    <= CNT_W'(edge_seen);
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                if (edge_seen && (edge_cnt != CNT_MAX))
                    edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACQ;
            good_cnt     <= '0;
            locked       <= 1'b0;
            fault_sticky <= 1'b0;
        end else begin
            // clear first so a same-cycle FAULT entry below overrides it
            if (fault_clr)
                fault_sticky <= 1'b0;
            case (state)
                ACQ: begin
                    if (stall) begin
                        good_cnt <= '0;
                    end else if (window_end) begin
                        if (!window_good) begin
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                            if (good_cnt == GOOD_LAST) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (stall || (window_end && !window_good)) begin
                        state        <= FAULT;
                        locked       <= 1'b0;
                        fault_sticky <= 1'b1;
                    end
                end
                FAULT: begin
                    state    <= ACQ;
                    good_cnt <= '0;
                end
                default: begin
                    state  <= ACQ;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rst_out_n <= 1'b0;
        else
            rst_out_n <= locked;
    end

endmodule

// File: tb/tb_pll_clk_monitor.sv
// tb/tb_pll_clk_monitor.sv - directed scoreboard bench for pll_clk_monitor
module tb_pll_clk_monitor;

    localparam int G     = 300;
    localparam int EXP_N = 20;
    localparam int TOL   = 4;
    localparam int LW    = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          meas_tog = 1'b0;
    logic          fault_clr = 1'b0;
    logic          locked;
    logic          rst_out_n;
    logic [CW-1:0] freq_count;
    logic          count_valid;
    logic          fault_sticky;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_tog_cyc = 0;

    typedef struct {
        int   cnt;
        logic lk;
        logic flt;
        logic rst_now;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic rst_chk_pending = 1'b0;
    logic rst_chk_val = 1'b0;

    pll_clk_monitor #(
        .GATE_CYCLES (G),
        .EXPECTED_CNT(EXP_N),
        .TOL_CNT     (TOL),
        .LOCK_WINDOWS(LW),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .meas_tog    (meas_tog),
        .fault_clr   (fault_clr),
        .locked      (locked),
        .rst_out_n   (rst_out_n),
        .freq_count  (freq_count),
        .count_valid (count_valid),
        .fault_sticky(fault_sticky)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One gate window: n toggles spread evenly, well clear of the window edges.
    // clr_mode 1 pulses fault_clr mid-window, 2 holds it on the wrap cycle.
    task automatic run_window(input int n, input logic lk, input logic flt,
                              input logic rst_now, input int clr_mode);
        int   step;
        exp_t e;
        step = (n > 0) ? (G - 16) / n : G;
        e = '{n, lk, flt, rst_now};
        sb.push_back(e);
        for (int i = 0; i < G; i++) begin
            @(posedge clk);
            #1;
            if (n > 0 && i >= 8 && ((i - 8) % step) == 0 && ((i - 8) / step) < n) begin
                meas_tog = ~meas_tog;
                last_tog_cyc = cyc;
            end
            fault_clr = (clr_mode == 1 && i == G / 2) || (clr_mode == 2 && i == G - 2);
        end
    endtask

    always @(negedge clk) begin
        if (rst_chk_pending) begin
            chk("rst_out_n_follow", {31'd0, rst_out_n}, {31'd0, rst_chk_val});
            chk("count_valid_1cyc", {31'd0, count_valid}, 32'd0);
            rst_chk_pending = 1'b0;
        end
        if (count_valid === 1'b1) begin
            chk("sb_has_entry", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("freq_count", 32'(freq_count), 32'(mon_e.cnt));
                chk("locked", {31'd0, locked}, {31'd0, mon_e.lk});
                chk("fault_sticky", {31'd0, fault_sticky}, {31'd0, mon_e.flt});
                chk("rst_out_n_at_valid", {31'd0, rst_out_n}, {31'd0, mon_e.rst_now});
                rst_chk_pending = 1'b1;
                rst_chk_val = mon_e.lk;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        chk("reset_freq_count", 32'(freq_count), 32'd0);
        chk("reset_count_valid", {31'd0, count_valid}, 32'd0);
        chk("reset_fault_sticky", {31'd0, fault_sticky}, 32'd0);
        rst_n = 1'b1;

        // acquisition with dithered counts, lock on the 4th good window
        run_window(19, 1'b0, 1'b0, 1'b0, 0);
        run_window(21, 1'b0, 1'b0, 1'b0, 0);
        run_window(20, 1'b0, 1'b0, 1'b0, 0);
        run_window(20, 1'b1, 1'b0, 1'b0, 0);
        run_window(20, 1'b1, 1'b0, 1'b1, 0);

        // out-of-band high count while locked, then re-lock
        run_window(25, 1'b0, 1'b1, 1'b1, 0);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b1, 1'b1, 1'b0, 0);

        // fault_clr away from any fault entry clears the sticky flag
        run_window(20, 1'b1, 1'b0, 1'b1, 1);

        // band edges; low edge-1 faults with fault_clr on the same cycle
        run_window(EXP_N - TOL, 1'b1, 1'b0, 1'b1, 0);
        run_window(EXP_N + TOL, 1'b1, 1'b0, 1'b1, 0);
        run_window(EXP_N - TOL - 1, 1'b0, 1'b1, 1'b1, 2);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(EXP_N - TOL - 1, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b0, 1'b1, 1'b0, 0);
        run_window(20, 1'b1, 1'b1, 1'b0, 0);

        // asynchronous reset mid-window while locked
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (i < 140 && (i % 10) == 5)
                meas_tog = ~meas_tog;
        end
        chk("pre_reset_locked", {31'd0, locked}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_locked", {31'd0, locked}, 32'd0);
        chk("midreset_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        chk("midreset_freq_count", 32'(freq_count), 32'd0);
        chk("midreset_fault_sticky", {31'd0, fault_sticky}, 32'd0);
        chk("midreset_count_valid", {31'd0, count_valid}, 32'd0);
        meas_tog = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(20, 1'b0, 1'b0, 1'b0, 0);
        run_window(20, 1'b0, 1'b0, 1'b0, 0);
        run_window(20, 1'b0, 1'b0, 1'b0, 0);
        run_window(20, 1'b1, 1'b0, 1'b0, 0);

        // meas_tog stops while locked
`ifdef PLLMON_STALL_DETECT_EN
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (locked !== 1'b1)
                break;
        end
        chk("stall_latency", 32'(cyc - last_tog_cyc), 32'd67);
        chk("stall_locked", {31'd0, locked}, 32'd0);
        chk("stall_fault_sticky", {31'd0, fault_sticky}, 32'd1);
        rst_n = 1'b0;
`else
        run_window(0, 1'b0, 1'b1, 1'b1, 0);
`endif
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
